// File: rtl/node_integrator.sv
// Explicit-Euler integrator for the soft-body loop: on each accepted force frame it
// updates velocity then position for one node per cycle, then pulses output_valid.
module node_integrator #(
  parameter int NUM_NODES     = 3,
  parameter int POSITION_SIZE = 8,
  parameter int VELOCITY_SIZE = 8,
  parameter int FORCE_SIZE    = 8,
  parameter int MASS_SHIFT    = 0,
  parameter int GRAVITY       = -1,
  parameter int DAMP_SHIFT    = 0
) (
  input  logic                                 clk_in,
  input  logic                                 rst_in,
  input  logic                                 load_in,
  input  logic signed [1:0][POSITION_SIZE-1:0] init_nodes      [NUM_NODES],
  input  logic signed [1:0][VELOCITY_SIZE-1:0] init_velocities [NUM_NODES],
  input  logic                                 input_valid,
  input  logic signed [1:0][FORCE_SIZE-1:0]    spring_forces   [NUM_NODES],
  output logic signed [1:0][POSITION_SIZE-1:0] nodes           [NUM_NODES],
  output logic signed [1:0][VELOCITY_SIZE-1:0] velocities      [NUM_NODES],
  output logic                                 busy,
  output logic                                 output_valid
);

  localparam int IW = (NUM_NODES > 1) ? $clog2(NUM_NODES) : 1;
  localparam int SW = VELOCITY_SIZE + FORCE_SIZE + 2;
  localparam int PW = ((POSITION_SIZE > VELOCITY_SIZE) ? POSITION_SIZE : VELOCITY_SIZE) + 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_NODES - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, UPDATE = 2'd1, DONE = 2'd2} state_t;

  state_t                          state;
  state_t                          state_next;
  logic [IW-1:0]                   idx;
  logic signed [1:0][FORCE_SIZE-1:0] force_buf [NUM_NODES];

  logic signed [SW-1:0]            acc   [2];
  logic signed [SW-1:0]            v_ext [2];
  logic signed [SW-1:0]            damp  [2];
  logic signed [SW-1:0]            v_sum [2];
  logic signed [PW-1:0]            p_sum [2];
  logic [1:0][VELOCITY_SIZE-1:0]   v_new;
  logic [1:0][POSITION_SIZE-1:0]   p_new;

  // Clamp a wide signed sum to VELOCITY_SIZE: in range iff the top bits are all sign copies.
  function automatic logic [VELOCITY_SIZE-1:0] sat_v(input logic signed [SW-1:0] x);
    logic [SW-VELOCITY_SIZE:0] top;
    top = x[SW-1:VELOCITY_SIZE-1];
    if ((&top) || !(|top)) sat_v = x[VELOCITY_SIZE-1:0];
    else if (x[SW-1])      sat_v = {1'b1, {(VELOCITY_SIZE-1){1'b0}}};
    else                   sat_v = {1'b0, {(VELOCITY_SIZE-1){1'b1}}};
  endfunction

  function automatic logic [POSITION_SIZE-1:0] sat_p(input logic signed [PW-1:0] x);
    logic [PW-POSITION_SIZE:0] top;
    top = x[PW-1:POSITION_SIZE-1];
    if ((&top) || !(|top)) sat_p = x[POSITION_SIZE-1:0];
    else if (x[PW-1])      sat_p = {1'b1, {(POSITION_SIZE-1){1'b0}}};
    else                   sat_p = {1'b0, {(POSITION_SIZE-1){1'b1}}};
  endfunction

  // Velocity and position update for the node at idx, both axes.
  always_comb begin
    v_new = '0;
    p_new = '0;
    for (int ax = 0; ax < 2; ax++) begin
      acc[ax]   = SW'($signed(force_buf[idx][ax])) >>> MASS_SHIFT;
      if (ax == 1) acc[ax] = acc[ax] + SW'(GRAVITY);
      else         acc[ax] = acc[ax];
      v_ext[ax] = SW'($signed(velocities[idx][ax]));
      if (DAMP_SHIFT == 0) damp[ax] = '0;
      else                 damp[ax] = v_ext[ax] >>> DAMP_SHIFT;
      v_sum[ax] = v_ext[ax] + acc[ax] - damp[ax];
      v_new[ax] = sat_v(v_sum[ax]);
      p_sum[ax] = PW'($signed(nodes[idx][ax])) + PW'($signed(v_new[ax]));
      p_new[ax] = sat_p(p_sum[ax]);
    end
  end

  // Next-state logic; load wins over a coincident force frame.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (load_in)          state_next = IDLE;
        else if (input_valid) state_next = UPDATE;
        else                  state_next = IDLE;
      end
      UPDATE: begin
        if (idx == LAST_IDX) state_next = DONE;
        else                 state_next = UPDATE;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk_in) begin
    if (rst_in) state <= IDLE;
    else        state <= state_next;
  end

  // busy stays up through the output_valid cycle so both drop on the same edge.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      idx          <= '0;
      busy         <= 1'b0;
      output_valid <= 1'b0;
      for (int i = 0; i < NUM_NODES; i++) begin
        nodes[i]      <= '0;
        velocities[i] <= '0;
        force_buf[i]  <= '0;
      end
    end else begin
      output_valid <= (state == DONE);
      busy         <= (state_next != IDLE) || (state == DONE);
      case (state)
        IDLE: begin
          if (load_in) begin
            nodes      <= init_nodes;
            velocities <= init_velocities;
          end else if (input_valid) begin
            force_buf <= spring_forces;
            idx       <= '0;
          end
        end
        UPDATE: begin
          velocities[idx] <= v_new;
          nodes[idx]      <= p_new;
          if (idx != LAST_IDX) idx <= idx + IW'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_node_integrator.sv
// Directed bench for node_integrator: table-driven frames on one instance
// (MASS_SHIFT=1, GRAVITY=-1) plus hand sequences and a damping instance.
module tb_node_integrator;

  typedef logic signed [1:0][7:0] vec_t;
  typedef logic [2:0][1:0][7:0]   frame_t;
  typedef struct packed {
    frame_t pos;
    frame_t vel;
    frame_t frc;
    frame_t epos;
    frame_t evel;
  } rec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic load_a = 1'b0, iv_a = 1'b0, busy_a, ov_a;
  logic load_b = 1'b0, iv_b = 1'b0, busy_b, ov_b;
  vec_t ip_a [3], iv0_a [3], f_a [3], n_a [3], v_a [3];
  vec_t ip_b [3], iv0_b [3], f_b [3], n_b [3], v_b [3];

  node_integrator #(.NUM_NODES(3), .MASS_SHIFT(1), .GRAVITY(-1), .DAMP_SHIFT(0)) dut_a (
    .clk_in(clk), .rst_in(rst), .load_in(load_a), .init_nodes(ip_a), .init_velocities(iv0_a),
    .input_valid(iv_a), .spring_forces(f_a), .nodes(n_a), .velocities(v_a),
    .busy(busy_a), .output_valid(ov_a));

  node_integrator #(.NUM_NODES(3), .MASS_SHIFT(0), .GRAVITY(0), .DAMP_SHIFT(2)) dut_b (
    .clk_in(clk), .rst_in(rst), .load_in(load_b), .init_nodes(ip_b), .init_velocities(iv0_b),
    .input_valid(iv_b), .spring_forces(f_b), .nodes(n_b), .velocities(v_b),
    .busy(busy_b), .output_valid(ov_b));

  int checks = 0;
  int errors = 0;
  rec_t tv [3];

  function automatic frame_t mk(input int x0, input int y0, input int x1, input int y1,
                                input int x2, input int y2);
    frame_t f;
    f[0][0] = 8'(x0); f[0][1] = 8'(y0);
    f[1][0] = 8'(x1); f[1][1] = 8'(y1);
    f[2][0] = 8'(x2); f[2][1] = 8'(y2);
    return f;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic load_frame(input bit b, input frame_t p, input frame_t v);
    for (int i = 0; i < 3; i++) begin
      if (b) begin ip_b[i] = p[i]; iv0_b[i] = v[i]; end
      else   begin ip_a[i] = p[i]; iv0_a[i] = v[i]; end
    end
    if (b) load_b = 1'b1; else load_a = 1'b1;
    tick;
    load_a = 1'b0;
    load_b = 1'b0;
  endtask

  task automatic set_forces(input bit b, input frame_t f);
    for (int i = 0; i < 3; i++) begin
      if (b) f_b[i] = f[i]; else f_a[i] = f[i];
    end
  endtask

  // Wait (bounded) for output_valid; returns edges counted after the call, -1 on timeout.
  task automatic wait_ov(input bit b, output int lat);
    lat = -1;
    for (int k = 1; k <= 20; k++) begin
      tick;
      if ((b ? ov_b : ov_a) === 1'b1) begin
        lat = k;
        break;
      end
    end
  endtask

  // Pulse input_valid, check busy, latency and one-cycle pulse shape.
  task automatic fire(input bit b, input frame_t f, input string tag);
    int lat;
    set_forces(b, f);
    if (b) iv_b = 1'b1; else iv_a = 1'b1;
    tick;
    iv_a = 1'b0;
    iv_b = 1'b0;
    chk({tag, " busy_rise"}, int'(b ? busy_b : busy_a), 1);
    wait_ov(b, lat);
    chk({tag, " ov_latency"}, lat, 4);
    tick;
    chk({tag, " ov_fall"}, int'(b ? ov_b : ov_a), 0);
    chk({tag, " busy_fall"}, int'(b ? busy_b : busy_a), 0);
  endtask

  task automatic compare(input bit b, input frame_t ep, input frame_t ev, input string tag);
    for (int i = 0; i < 3; i++) begin
      for (int ax = 0; ax < 2; ax++) begin
        chk($sformatf("%s pos[%0d][%0d]", tag, i, ax),
            int'($signed(b ? n_b[i][ax] : n_a[i][ax])), int'($signed(ep[i][ax])));
        chk($sformatf("%s vel[%0d][%0d]", tag, i, ax),
            int'($signed(b ? v_b[i][ax] : v_a[i][ax])), int'($signed(ev[i][ax])));
      end
    end
  endtask

  task automatic count_ov(input bit b, input int n, output int cnt);
    cnt = 0;
    for (int k = 0; k < n; k++) begin
      tick;
      if ((b ? ov_b : ov_a) === 1'b1) cnt++;
    end
  endtask

  initial begin
    int cnt;
    int lat;
    frame_t zero_f;
    frame_t big_f;
    zero_f = mk(0, 0, 0, 0, 0, 0);
    big_f  = mk(100, 100, 100, 100, 100, 100);

    tv[0].pos  = mk(3, 4, 6, 8, 12, -2);
    tv[0].vel  = mk(1, 2, -2, -3, 5, 8);
    tv[0].frc  = mk(4, -4, 0, 0, -8, 8);
    tv[0].epos = mk(6, 3, 4, 4, 13, 9);
    tv[0].evel = mk(3, -1, -2, -4, 1, 11);

    tv[1].pos  = mk(100, 100, -100, -100, 10, 10);
    tv[1].vel  = mk(120, 120, -120, -120, 0, 0);
    tv[1].frc  = mk(40, 40, -40, -40, -1, -1);
    tv[1].epos = mk(127, 127, -128, -128, 9, 8);
    tv[1].evel = mk(127, 127, -128, -128, -1, -2);

    tv[2].pos  = mk(-128, 127, 0, 0, -3, -5);
    tv[2].vel  = mk(-1, 1, 127, -128, 7, -7);
    tv[2].frc  = mk(0, 2, -2, -2, 3, 3);
    tv[2].epos = mk(-128, 127, 126, -128, 5, -12);
    tv[2].evel = mk(-1, 1, 126, -128, 8, -7);

    for (int i = 0; i < 3; i++) begin
      ip_a[i] = '0; iv0_a[i] = '0; f_a[i] = '0;
      ip_b[i] = '0; iv0_b[i] = '0; f_b[i] = '0;
    end

    tick;
    tick;
    rst = 1'b0;
    tick;
    chk("reset busy", int'(busy_a), 0);
    chk("reset ov", int'(ov_a), 0);
    compare(1'b0, zero_f, zero_f, "reset");

    // Table-driven frames.
    for (int t = 0; t < 3; t++) begin
      load_frame(1'b0, tv[t].pos, tv[t].vel);
      compare(1'b0, tv[t].pos, tv[t].vel, $sformatf("load%0d", t));
      fire(1'b0, tv[t].frc, $sformatf("vec%0d", t));
      compare(1'b0, tv[t].epos, tv[t].evel, $sformatf("vec%0d", t));
    end

    // Damping on the second instance.
    load_frame(1'b1, mk(0, 0, 50, -50, -5, 5), mk(16, -16, -8, 8, 0, 0));
    fire(1'b1, mk(0, 0, 0, 0, 4, -3), "damp");
    compare(1'b1, mk(12, -12, 44, -44, -1, 2), mk(12, -12, -6, 6, 4, -3), "damp");

    // Second pulse and load during UPDATE are ignored.
    load_frame(1'b0, tv[0].pos, tv[0].vel);
    set_forces(1'b0, tv[0].frc);
    iv_a = 1'b1;
    tick;
    iv_a = 1'b0;
    tick;
    chk("mid-frame node2 hold", int'($signed(n_a[2][0])), 12);
    set_forces(1'b0, big_f);
    for (int i = 0; i < 3; i++) ip_a[i] = big_f[i];
    iv_a = 1'b1;
    load_a = 1'b1;
    tick;
    iv_a = 1'b0;
    load_a = 1'b0;
    count_ov(1'b0, 10, cnt);
    chk("busy ignore ov count", cnt, 1);
    compare(1'b0, tv[0].epos, tv[0].evel, "busy ignore");

    // Reset at the edge that would write node 1.
    load_frame(1'b0, tv[0].pos, tv[0].vel);
    set_forces(1'b0, tv[0].frc);
    iv_a = 1'b1;
    tick;
    iv_a = 1'b0;
    tick;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    chk("abort busy", int'(busy_a), 0);
    chk("abort ov", int'(ov_a), 0);
    compare(1'b0, zero_f, zero_f, "abort");
    count_ov(1'b0, 8, cnt);
    chk("abort ov count", cnt, 0);

    // load_in and input_valid together: load only.
    for (int i = 0; i < 3; i++) begin
      ip_a[i] = tv[0].pos[i];
      iv0_a[i] = tv[0].vel[i];
    end
    set_forces(1'b0, tv[0].frc);
    load_a = 1'b1;
    iv_a = 1'b1;
    tick;
    load_a = 1'b0;
    iv_a = 1'b0;
    chk("load+iv busy", int'(busy_a), 0);
    count_ov(1'b0, 8, cnt);
    chk("load+iv ov count", cnt, 0);
    compare(1'b0, tv[0].pos, tv[0].vel, "load+iv");

    // Back-to-back: next input_valid accepted at the output_valid edge.
    set_forces(1'b0, tv[0].frc);
    iv_a = 1'b1;
    tick;
    iv_a = 1'b0;
    wait_ov(1'b0, lat);
    chk("b2b first latency", lat, 4);
    set_forces(1'b0, zero_f);
    iv_a = 1'b1;
    tick;
    iv_a = 1'b0;
    chk("b2b busy held", int'(busy_a), 1);
    wait_ov(1'b0, lat);
    chk("b2b second gap", lat + 1, 5);
    chk("b2b node0 x", int'($signed(n_a[0][0])), 9);
    chk("b2b node0 y", int'($signed(n_a[0][1])), 1);
    chk("b2b vel0 y", int'($signed(v_a[0][1])), -2);
    chk("b2b node1 y", int'($signed(n_a[1][1])), -1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
